// File: rtl/mem_wb_skid_pkg.sv
// Shared constants and types for the MEM/WB writeback skid stage.
package mem_wb_skid_pkg;

    localparam logic        RstEnable    = 1'b1;
    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    // One writeback lane at the default core widths.
    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0] wd;
        logic                      wreg;
        logic [DEFAULT_DATA_W-1:0] wdata;
    } wb_lane_t;

    // Bit width of one packed lane for arbitrary address/data widths.
    function automatic int lane_width(input int addr_w, input int data_w);
        return addr_w + 1 + data_w;
    endfunction

endpackage

// File: rtl/mem_wb_skid_skid_buf2.sv
// Generic 2-entry valid/ready skid buffer; in_ready is a pure register output.
module skid_buf2
    import mem_wb_skid_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] m_data;
    logic [W-1:0] s_data;
    logic         mv;
    logic         sv;
    logic         accept;
    logic         drain;

    assign in_ready  = !sv;
    assign out_valid = mv;
    assign out_data  = m_data;
    assign accept    = in_valid && !sv;
    assign drain     = mv && out_ready;

    // Flush clears valids only; the main payload is left stale on purpose.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            mv     <= 1'b0;
            sv     <= 1'b0;
            m_data <= '0;
            s_data <= '0;
        end else if (flush) begin
            mv <= 1'b0;
            sv <= 1'b0;
        end else if (drain && sv) begin
            m_data <= s_data;
            sv     <= 1'b0;
        end else if (accept && (!mv || drain)) begin
            m_data <= in_data;
            mv     <= 1'b1;
        end else if (drain) begin
            mv <= 1'b0;
        end else if (accept) begin
            s_data <= in_data;
            sv     <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_wb_skid.sv
// Multi-lane MEM/WB register with skid buffer, flush and x0 write suppression.
// Optional stall counter output enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_skid
    import mem_wb_skid_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ADDR_W    = DEFAULT_ADDR_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_LANES*ADDR_W-1:0] in_wd,
    input  logic [NUM_LANES-1:0]        in_wreg,
    input  logic [NUM_LANES*DATA_W-1:0] in_wdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NUM_LANES*ADDR_W-1:0] wb_wd,
    output logic [NUM_LANES-1:0]        wb_wreg,
    output logic [NUM_LANES*DATA_W-1:0] wb_wdata
`ifdef MEM_WB_STALL_CNT_EN
    ,
    output logic [31:0]                 stall_cnt
`endif
);

    localparam int LANE_W = lane_width(ADDR_W, DATA_W);
    localparam int PAY_W  = NUM_LANES * LANE_W;

    logic [PAY_W-1:0]     in_payload;
    logic [PAY_W-1:0]     out_payload;
    logic [NUM_LANES-1:0] stored_wreg;

    // Writes to x0 are dropped at capture so writeback never sees them.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic lane_we;
        assign lane_we = (in_wd[i*ADDR_W +: ADDR_W] != '0) ? in_wreg[i] : WriteDisable;
        assign in_payload[i*LANE_W +: LANE_W] =
            {in_wd[i*ADDR_W +: ADDR_W], lane_we, in_wdata[i*DATA_W +: DATA_W]};
        assign {wb_wd[i*ADDR_W +: ADDR_W], stored_wreg[i], wb_wdata[i*DATA_W +: DATA_W]} =
            out_payload[i*LANE_W +: LANE_W];
    end

    skid_buf2 #(
        .W(PAY_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign wb_wreg = stored_wreg & {NUM_LANES{out_valid}};

`ifdef MEM_WB_STALL_CNT_EN
    // Saturating stall counter; only reset clears it, flush does not.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised successor of the single-lane MEM/WB pipeline register for the RISC-V core.
- Carries NUM_LANES independent writeback lanes (rd address, write-enable, data) from the memory-access stage to register-file writeback.
- Adds a valid/ready handshake with a 2-entry skid buffer, so backpressure from writeback no longer combinationally reaches the MEM stage.
- Adds a synchronous flush and hardware suppression of writes to x0.

Parameters:
- NUM_LANES, 1, number of parallel writeback lanes (1..4).
- DATA_W, 32, writeback data width per lane.
- ADDR_W, 5, register address width per lane.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  discards all buffered and incoming beats this cycle.
- in_valid  in  1  MEM stage presents a beat.
- in_ready  out  1  stage can accept a beat; driven straight from a register.
- in_wd  in  NUM_LANES*ADDR_W  destination register per lane; lane i is at bits [i*ADDR_W +: ADDR_W].
- in_wreg  in  NUM_LANES  write-enable per lane.
- in_wdata  in  NUM_LANES*DATA_W  write data per lane.
- out_valid  out  1  a beat is presented to writeback.
- out_ready  in  1  writeback consumes the beat.
- wb_wd  out  NUM_LANES*ADDR_W  registered destination addresses.
- wb_wreg  out  NUM_LANES  registered write-enables, gated by out_valid.
- wb_wdata  out  NUM_LANES*DATA_W  registered write data.

Behaviour:
- Storage:
  - main register M with valid bit mv; skid register S with valid bit sv.
  - out_valid = mv; outputs come from M only.
  - in_ready = !sv.
- Transfers:
  - Accept = in_valid && in_ready.
  - Drain = mv && out_ready.
- Reset (rst=1 at the edge):
  - mv=0, sv=0.
  - wb_wd = all zeros (NOP address), wb_wreg = 0, wb_wdata = all zeros.
  - The outputs therefore read in_ready=1, out_valid=0 immediately after reset.
  - Reset overrides flush and any in-flight beat; an incoming beat in the reset cycle is lost.
- Flush (rst=0, flush=1):
  - mv=0 and sv=0; any incoming beat in the same cycle is dropped, even if in_valid=1.
  - wb_wreg is forced to 0 for the following cycle. wb_wd and wb_wdata hold their values and are don't-care.
- Normal update, priority order:
  - Drain and sv=1: S moves into M and sv clears. An Accept cannot occur in this case, because in_ready=0.
  - Drain and Accept with sv=0: the input loads into M and mv stays 1.
  - Drain only: mv=0.
  - Accept and (mv=0 or Drain): the input loads into M and mv=1.
  - Accept while mv=1 and no Drain: the input loads into S and sv=1, so in_ready drops next cycle.
  - Neither Accept nor Drain: hold M and S.
- Beats leave in acceptance order; none are duplicated or lost unless flush or reset discards them.
- Latency: a beat accepted at edge t appears at out_valid after t when M was free or draining. Throughput is 1 beat/cycle with out_ready held high.
- x0 suppression: on capture, lane i has wreg stored as in_wreg[i] && (in_wd lane i != 0). The address and data are stored unchanged.
- wb_wreg = stored wreg AND out_valid, so no write-enable is ever seen while the stage is invalid.
- Lanes are independent and carry no cross-lane arbitration. Two lanes targeting the same rd are passed through as-is; the register file resolves them (highest lane wins).

Optional Feature:
- Macro: MEM_WB_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (out, 32): the number of cycles with out_valid=1 && out_ready=0.
  - It saturates at 0xFFFFFFFF and clears on rst only; flush does not clear it.
- When undefined: the port and the counter do not exist, and all other behaviour is identical.

Decomposition:
- Shared package/defines:
  - RstEnable, WriteEnable/WriteDisable, ZeroWord, NOPRegAddr.
  - Default DATA_W/ADDR_W, and a writeback-lane struct/typedef {wd, wreg, wdata}.
- Sub-module skid_buf2: a generic 2-entry valid/ready skid buffer parametrised by payload width.
  - mem_wb_skid instantiates one skid_buf2 with payload NUM_LANES*(ADDR_W+1+DATA_W).
  - It adds the x0 gating on input, the out_valid gating on wb_wreg, and the optional counter around it.

Test Plan:
- Reset: rst=1 for 2 cycles while in_valid=1 -> out_valid=0, wb_wreg=0, wb_wd=0, wb_wdata=0, in_ready=1 after release.
- Streaming: NUM_LANES=2, out_ready=1, beats {wd=5,wdata=0xA5A5A5A5,we=1 / wd=7,wdata=0x1,we=1} on consecutive cycles -> each beat appears 1 cycle later, in order, with no bubbles.
- Backpressure: out_ready=0 after the first beat, three beats offered -> beats 1 and 2 are held, in_ready=0 after the second accept, and the third is not taken. Raising out_ready delivers 1, 2, 3 in order with no loss.
- Flush: M and S both full, flush=1 with in_valid=1 -> next cycle out_valid=0, wb_wreg=0, in_ready=1, and the dropped beat never appears.
- x0 suppression: beat with wd=0, wreg=1, wdata=0xDEADBEEF -> wb_wreg lane=0, wb_wdata=0xDEADBEEF.
- Stall counter (macro defined): out_valid held with out_ready=0 for 10 cycles -> stall_cnt=10. A flush leaves it at 10; rst clears it to 0.
